// File: rtl/hub75_scan_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : hub75_scan_ctrl
//  Description : HUB75 scan sequencer. Shifts one row of a BCM bit plane,
//                blanks, latches, then displays for on_time << plane cycles.
//                Also issues framebuffer read requests for each column.
//  Revision    : 1.0 - initial release
// ============================================================================
module hub75_scan_ctrl #(
    parameter int COLS       = 64,
    parameter int ROW_ADDR_W = 5,
    parameter int BITPLANES  = 8,
    parameter int ONT_W      = 8,
    localparam int COL_W     = $clog2(COLS),
    localparam int PLANE_W   = (BITPLANES > 1) ? $clog2(BITPLANES) : 1
) (
    input  logic                  ACLK,
    input  logic                  ARESETN,
    input  logic                  cfg_enable,
    input  logic [ONT_W-1:0]      cfg_on_time,
    output logic                  fb_rd_en,
    output logic [COL_W-1:0]      fb_col,
    output logic [ROW_ADDR_W-1:0] fb_row,
    output logic [PLANE_W-1:0]    fb_plane,
    output logic                  panel_clk,
    output logic                  panel_lat,
    output logic                  panel_oe_n,
    output logic [ROW_ADDR_W-1:0] panel_row,
    output logic                  frame_done,
    output logic                  busy
);

    localparam int CNT_W = ONT_W + BITPLANES - 1;

    localparam logic [COL_W-1:0]      c_last_col   = COL_W'(COLS - 1);
    localparam logic [PLANE_W-1:0]    c_last_plane = PLANE_W'(BITPLANES - 1);
    localparam logic [ROW_ADDR_W-1:0] c_last_row   = {ROW_ADDR_W{1'b1}};

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_SHIFT   = 3'd1,
        ST_BLANK   = 3'd2,
        ST_LATCH   = 3'd3,
        ST_DISPLAY = 3'd4
    } state_t;

    state_t                  state_q,       state_d;
    logic [COL_W-1:0]        col_q,         col_d;
    logic                    phase_q,       phase_d;
    logic [ROW_ADDR_W-1:0]   row_q,         row_d;
    logic [PLANE_W-1:0]      plane_q,       plane_d;
    logic [CNT_W-1:0]        cnt_q,         cnt_d;
    logic [ONT_W-1:0]        on_shadow_q,   on_shadow_d;
    logic [ROW_ADDR_W-1:0]   panel_row_q,   panel_row_d;

    logic                    w_plane_end;
    logic                    w_frame_end;
    logic [CNT_W-1:0]        w_on_product;

    // Display length of the current plane: base on-time weighted by 2**plane.
    assign w_on_product = CNT_W'(on_shadow_q) << plane_q;
    assign w_frame_end  = (row_q == c_last_row) && (plane_q == c_last_plane);

    // State and counter registers; async reset puts every output at rest.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            state_q     <= ST_IDLE;
            col_q       <= '0;
            phase_q     <= 1'b0;
            row_q       <= '0;
            plane_q     <= '0;
            cnt_q       <= '0;
            on_shadow_q <= '0;
            panel_row_q <= '0;
        end else begin
            state_q     <= state_d;
            col_q       <= col_d;
            phase_q     <= phase_d;
            row_q       <= row_d;
            plane_q     <= plane_d;
            cnt_q       <= cnt_d;
            on_shadow_q <= on_shadow_d;
            panel_row_q <= panel_row_d;
        end
    end

    // Next-state, counter updates and decoded panel/framebuffer strobes.
    always_comb begin
        state_d     = state_q;
        col_d       = col_q;
        phase_d     = phase_q;
        row_d       = row_q;
        plane_d     = plane_q;
        cnt_d       = cnt_q;
        on_shadow_d = on_shadow_q;
        panel_row_d = panel_row_q;
        w_plane_end = 1'b0;
        fb_rd_en    = 1'b0;
        panel_clk   = 1'b0;
        panel_lat   = 1'b0;
        panel_oe_n  = 1'b1;
        frame_done  = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                col_d   = '0;
                phase_d = 1'b0;
                row_d   = '0;
                plane_d = '0;
                if (cfg_enable) begin
                    on_shadow_d = cfg_on_time;
                    state_d     = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (!phase_q) begin
                    // Phase A: fetch; datapath gets the word next cycle.
                    fb_rd_en = 1'b1;
                    phase_d  = 1'b1;
                end else begin
                    // Phase B: rising shift clock clocks the fetched word in.
                    panel_clk = 1'b1;
                    phase_d   = 1'b0;
                    if (col_q == c_last_col) begin
                        col_d   = '0;
                        state_d = ST_BLANK;
                    end else begin
                        col_d = col_q + COL_W'(1);
                    end
                end
            end
            ST_BLANK: begin
                // Row address moves together with the latch pulse.
                panel_row_d = row_q;
                state_d     = ST_LATCH;
            end
            ST_LATCH: begin
                panel_lat = 1'b1;
                if (w_on_product != '0) begin
                    cnt_d   = w_on_product - CNT_W'(1);
                    state_d = ST_DISPLAY;
                end else begin
                    w_plane_end = 1'b1;
                end
            end
            ST_DISPLAY: begin
                panel_oe_n = 1'b0;
                if (cnt_q == '0) begin
                    w_plane_end = 1'b1;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // End of a plane: pick the next plane/row, restart frame or stop.
        if (w_plane_end) begin
            frame_done = w_frame_end;
            if (!cfg_enable) begin
                row_d   = '0;
                plane_d = '0;
                state_d = ST_IDLE;
            end else if (w_frame_end) begin
                row_d       = '0;
                plane_d     = '0;
                on_shadow_d = cfg_on_time;
                state_d     = ST_SHIFT;
            end else begin
                if (plane_q == c_last_plane) begin
                    plane_d = '0;
                    row_d   = row_q + ROW_ADDR_W'(1);
                end else begin
                    plane_d = plane_q + PLANE_W'(1);
                end
                state_d = ST_SHIFT;
            end
        end
    end

    assign fb_col    = col_q;
    assign fb_row    = row_q;
    assign fb_plane  = plane_q;
    assign panel_row = panel_row_q;
    assign busy      = (state_q != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_hub75_scan_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_hub75_scan_ctrl
//  Description : Self-checking bench for hub75_scan_ctrl. A plane-level
//                reference model expands each plane into its expected cycle
//                sequence; random on-time / enable stimulus is compared
//                cycle by cycle against it.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_hub75_scan_ctrl;

    localparam int COLS       = 4;
    localparam int ROW_ADDR_W = 1;
    localparam int BITPLANES  = 2;
    localparam int ONT_W      = 8;
    localparam int COL_W      = 2;
    localparam int PL_W       = 1;
    localparam int ROWS       = 2 ** ROW_ADDR_W;

    logic                  ACLK = 1'b0;
    logic                  ARESETN = 1'b0;
    logic                  cfg_enable = 1'b0;
    logic [ONT_W-1:0]      cfg_on_time = '0;
    logic                  fb_rd_en;
    logic [COL_W-1:0]      fb_col;
    logic [ROW_ADDR_W-1:0] fb_row;
    logic [PL_W-1:0]       fb_plane;
    logic                  panel_clk;
    logic                  panel_lat;
    logic                  panel_oe_n;
    logic [ROW_ADDR_W-1:0] panel_row;
    logic                  frame_done;
    logic                  busy;

    hub75_scan_ctrl #(
        .COLS       (COLS),
        .ROW_ADDR_W (ROW_ADDR_W),
        .BITPLANES  (BITPLANES),
        .ONT_W      (ONT_W)
    ) u_dut (
        .ACLK        (ACLK),
        .ARESETN     (ARESETN),
        .cfg_enable  (cfg_enable),
        .cfg_on_time (cfg_on_time),
        .fb_rd_en    (fb_rd_en),
        .fb_col      (fb_col),
        .fb_row      (fb_row),
        .fb_plane    (fb_plane),
        .panel_clk   (panel_clk),
        .panel_lat   (panel_lat),
        .panel_oe_n  (panel_oe_n),
        .panel_row   (panel_row),
        .frame_done  (frame_done),
        .busy        (busy)
    );

    always #5 ACLK = ~ACLK;

    typedef struct packed {
        logic                  rd_en;
        logic                  pclk;
        logic                  lat;
        logic                  oe_n;
        logic                  fdone;
        logic                  busy;
        logic [ROW_ADDR_W-1:0] prow;
        logic [COL_W-1:0]      col;
        logic [ROW_ADDR_W-1:0] row;
        logic [PL_W-1:0]       plane;
    } exp_t;

    exp_t q_exp[$];
    int   n_checks = 0;
    int   n_errors = 0;

    // Reference model state (plane granularity).
    int   m_active = 0;
    int   m_row    = 0;
    int   m_plane  = 0;
    int   m_t      = 0;
    int   m_prow   = 0;

    // Inputs as the DUT saw them at the most recent rising edge.
    logic             en_at_edge;
    logic [ONT_W-1:0] on_at_edge;

    // Capture inputs seen by the DUT at each rising edge.
    always @(posedge ACLK) begin
        en_at_edge = cfg_enable;
        on_at_edge = cfg_on_time;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s @%0t: got %0h, expected %0h", tag, $time, got, exp);
        end
    endtask

    task automatic push_idle();
        exp_t e;
        e      = '0;
        e.oe_n = 1'b1;
        e.prow = ROW_ADDR_W'(m_prow);
        q_exp.push_back(e);
    endtask

    // Expand one plane: shift, blank, latch, display.
    task automatic push_plane();
        exp_t e;
        int   len;
        int   last;
        for (int c = 0; c < COLS; c++) begin
            e       = '0;
            e.rd_en = 1'b1;
            e.oe_n  = 1'b1;
            e.busy  = 1'b1;
            e.prow  = ROW_ADDR_W'(m_prow);
            e.col   = COL_W'(c);
            e.row   = ROW_ADDR_W'(m_row);
            e.plane = PL_W'(m_plane);
            q_exp.push_back(e);
            e.rd_en = 1'b0;
            e.pclk  = 1'b1;
            q_exp.push_back(e);
        end
        e      = '0;
        e.oe_n = 1'b1;
        e.busy = 1'b1;
        e.prow = ROW_ADDR_W'(m_prow);
        q_exp.push_back(e);
        m_prow = m_row;
        len    = m_t << m_plane;
        last   = (m_row == ROWS - 1) && (m_plane == BITPLANES - 1);
        e      = '0;
        e.lat  = 1'b1;
        e.oe_n = 1'b1;
        e.busy = 1'b1;
        e.prow = ROW_ADDR_W'(m_prow);
        e.fdone = (len == 0) && (last != 0);
        q_exp.push_back(e);
        for (int i = 0; i < len; i++) begin
            e       = '0;
            e.busy  = 1'b1;
            e.prow  = ROW_ADDR_W'(m_prow);
            e.fdone = (last != 0) && (i == len - 1);
            q_exp.push_back(e);
        end
    endtask

    // Decide what comes after the last generated plane / idle cycle.
    task automatic gen_next();
        int fend;
        if (m_active == 0) begin
            if (en_at_edge) begin
                m_active = 1;
                m_row    = 0;
                m_plane  = 0;
                m_t      = int'(on_at_edge);
                push_plane();
            end else begin
                push_idle();
            end
        end else begin
            fend = (m_row == ROWS - 1) && (m_plane == BITPLANES - 1);
            if (!en_at_edge) begin
                m_active = 0;
                push_idle();
            end else if (fend != 0) begin
                m_row   = 0;
                m_plane = 0;
                m_t     = int'(on_at_edge);
                push_plane();
            end else begin
                if (m_plane == BITPLANES - 1) begin
                    m_plane = 0;
                    m_row++;
                end else begin
                    m_plane++;
                end
                push_plane();
            end
        end
    endtask

    // One clock: sample on the falling edge and compare with the model.
    task automatic run_cycle(output exp_t e);
        @(negedge ACLK);
        if (q_exp.size() == 0) gen_next();
        e = q_exp.pop_front();
        check("ctl", {fb_rd_en, panel_clk, panel_lat, panel_oe_n, frame_done, busy},
                     {e.rd_en, e.pclk, e.lat, e.oe_n, e.fdone, e.busy});
        check("panel_row", panel_row, e.prow);
        if (e.rd_en) check("fb_addr", {fb_col, fb_row, fb_plane}, {e.col, e.row, e.plane});
    endtask

    initial begin
        exp_t e;
        int   found;

        cfg_enable  = 1'b1;
        cfg_on_time = 8'd3;
        ARESETN     = 1'b0;
        repeat (3) @(negedge ACLK);
        check("rst_oe_n", panel_oe_n, 1'b1);
        check("rst_busy", busy, 1'b0);
        check("rst_strobes", {fb_rd_en, panel_clk, panel_lat, frame_done}, 4'h0);
        check("rst_addr", {fb_col, fb_row, fb_plane}, '0);
        check("rst_panel_row", panel_row, '0);
        ARESETN = 1'b1;

        // Nominal scan, on-time changed mid-frame.
        repeat (20) run_cycle(e);
        cfg_on_time = 8'd5;
        repeat (150) run_cycle(e);

        // Zero on-time: display skipped entirely.
        cfg_on_time = 8'd0;
        repeat (130) run_cycle(e);

        // Drop enable during the shift of row 1 plane 0.
        cfg_on_time = 8'd3;
        found = 0;
        for (int i = 0; i < 400 && found == 0; i++) begin
            run_cycle(e);
            if (e.rd_en && e.row == 1 && e.plane == 0) found = 1;
        end
        check("find_r1p0", found, 1);
        cfg_enable = 1'b0;
        repeat (40) run_cycle(e);
        check("idle_busy", busy, 1'b0);
        cfg_enable = 1'b1;
        repeat (80) run_cycle(e);

        // Random on-time and enable activity.
        for (int i = 0; i < 1500; i++) begin
            run_cycle(e);
            if ($urandom_range(0, 29) == 0) cfg_on_time = 8'($urandom_range(0, 7));
            if ($urandom_range(0, 99) == 0) cfg_enable = ~cfg_enable;
        end

        // Asynchronous reset in the middle of a display period.
        cfg_enable  = 1'b1;
        cfg_on_time = 8'd3;
        found = 0;
        for (int i = 0; i < 400 && found == 0; i++) begin
            run_cycle(e);
            if (!e.oe_n) found = 1;
        end
        check("find_display", found, 1);
        #2 ARESETN = 1'b0;
        #1;
        check("async_oe_n", panel_oe_n, 1'b1);
        check("async_busy", busy, 1'b0);
        check("async_strobes", {fb_rd_en, panel_clk, panel_lat, frame_done}, 4'h0);
        check("async_panel_row", panel_row, '0);
        q_exp.delete();
        m_active = 0;
        m_prow   = 0;
        repeat (2) @(negedge ACLK);
        ARESETN = 1'b1;
        repeat (100) run_cycle(e);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
